peak_select: RTL
================

PEAK_SELECT -- requirements
Module: peak_select

Interface
REQ-001 Parameter PEAKS, default 6, number of retained peaks per frame.
REQ-002 Parameter FREQS, default 256, bins per FFT frame.
REQ-003 Parameter INPUT_AMPL_WIDTH, default 24, candidate amplitude width.
REQ-004 Parameter FINAL_AMPL_WIDTH, default 16, reported amplitude width.
REQ-005 Parameter FREQ_WIDTH, default 8, bin index width (>= clog2(FREQS)).
REQ-006 One clock; reset is asynchronous and active-high. Clock is CLOCK_50; reset is reset.
REQ-007 CLOCK_50  in  1  system clock.
REQ-008 reset  in  1  async active-high reset.
REQ-009 cand_valid  in  1  candidate bin present.
REQ-010 cand_ready  out  1  block accepts candidate this cycle.
REQ-011 cand_ampl  in  INPUT_AMPL_WIDTH  bin amplitude.
REQ-012 cand_is_peak  in  1  peak_finder flag for this bin.
REQ-013 cand_last  in  1  final bin of frame.
REQ-014 out_valid  out  1  peak list available.
REQ-015 out_ready  in  1  consumer takes peak list.
REQ-016 amplitude  out  [PEAKS] x FINAL_AMPL_WIDTH  peak amplitudes, slot 0 largest.
REQ-017 freq  out  [PEAKS] x FREQ_WIDTH  bin index per slot.
REQ-018 slot_valid  out  PEAKS  slot holds a real peak.
REQ-019 overrun  out  1  sticky: frame exceeded FREQS bins.

Function
REQ-020 A transfer occurs when cand_valid && cand_ready; bin index = count of transfers since frame start, starting at 0.
REQ-021 States: COLLECT (cand_ready=1), HOLD (cand_ready=0, out_valid=1); reset state COLLECT.
REQ-022 In COLLECT, a transfer with cand_is_peak=1 inserts (amplitude, index) into the sorted list in the same cycle: amplitude-descending, ties keep the earlier bin ahead, lowest entry drops when full.
REQ-023 Transfers with cand_is_peak=0 only advance the bin index.
REQ-024 Throughput: one candidate per cycle in COLLECT, no bubbles.
REQ-025 Transfer with cand_last=1: include that bin, latch the list into output registers, go to HOLD; out_valid asserts the next cycle (latency 1).
REQ-026 In HOLD, outputs stay stable; out_valid && out_ready returns to COLLECT with the working list cleared and the bin index set to 0.
REQ-027 Reported amplitude = cand_ampl[INPUT_AMPL_WIDTH-1 -: FINAL_AMPL_WIDTH] (MSB truncation, no rounding).
REQ-028 Unfilled slots: slot_valid=0, amplitude=0, freq=0.
REQ-029 At bin index FREQS-1 without cand_last: overrun sets, and that bin is treated as last.
REQ-030 Further bins are excluded from the frame.
REQ-031 overrun clears only on reset.
REQ-032 Frame of zero peaks still produces out_valid with all slot_valid=0.

Reset
REQ-033 Reset asserted, at any time (including mid-frame or HOLD):
- state = COLLECT; working list cleared; bin index = 0.
- out_valid=0, cand_ready=0 while asserted.
- amplitude/freq all 0; slot_valid=0; overrun=0.
- Partial frame discarded.
REQ-034 First transfer after reset deassertion is bin 0.

Configuration
REQ-035 PEAK_THRESHOLD_EN defined: extra input port threshold (INPUT_AMPL_WIDTH); a peak inserts only if cand_ampl >= threshold, sampled per transfer.
REQ-036 PEAK_THRESHOLD_EN undefined: no threshold port; every flagged peak is eligible.

Structure
REQ-037 Shared package peaks_pkg holds:
- constants PEAKS, FREQS, INPUT_AMPL_WIDTH, FINAL_AMPL_WIDTH, FREQ_WIDTH;
- typedef peak_entry_t {valid, ampl, freq}.
REQ-038 One sub-module peak_insert: combinational compare-and-shift of one entry into the PEAKS-deep sorted list.
REQ-039 peak_select holds the FSM, bin counter and registers.

Verification
REQ-040 Frame of 256 bins, peaks at bins 10/50/90 with ampl 300/900/600 -> slots 0..2 = (900,50),(600,90),(300,10); slot_valid=000111.
REQ-041 Eight peaks with ampl 1..8 -> slots hold 8..3; bins with ampl 1,2 dropped.
REQ-042 Equal ampl 500 at bins 5 and 7 -> bin 5 in the higher slot.
REQ-043 out_ready low for 10 cycles after out_valid -> cand_ready=0 and outputs stable throughout.
- Next frame starts at bin 0 after the handshake.
REQ-044 Reset pulse mid-frame at bin 100 -> outputs zero.
- Next frame reports only post-reset peaks from bin 0.
REQ-045 No cand_last within 256 bins -> overrun=1; out_valid after bin 255.
- With PEAK_THRESHOLD_EN and threshold=400: a peak with ampl 300 is excluded.

Source files
------------

// File: rtl/peaks_pkg.sv
// Shared constants, list-entry type and FSM encoding for peak_select.
// The entry keeps the full input amplitude so ordering uses every bit.
package peaks_pkg;
  localparam int PEAKS            = 6;
  localparam int FREQS            = 256;
  localparam int INPUT_AMPL_WIDTH = 24;
  localparam int FINAL_AMPL_WIDTH = 16;
  localparam int FREQ_WIDTH       = 8;

  typedef struct packed {
    logic                        valid;
    logic [INPUT_AMPL_WIDTH-1:0] ampl;
    logic [FREQ_WIDTH-1:0]       freq;
  } peak_entry_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/peak_insert.sv
// Combinational insert of one entry into the amplitude-descending peak list.
// Ties keep existing (earlier) entries ahead; the lowest entry falls off when full.
module peak_insert
  import peaks_pkg::*;
(
  input  peak_entry_t [PEAKS-1:0] i_list,
  input  peak_entry_t             i_entry,
  input  logic                    i_en,
  output peak_entry_t [PEAKS-1:0] o_list
);
  logic [PEAKS-1:0] w_ge;

  always_comb begin
    for (int i = 0; i < PEAKS; i++) begin
      w_ge[i] = i_list[i].valid && (i_list[i].ampl >= i_entry.ampl);
    end
  end

  // Valid entries are contiguous from slot 0, so the new entry lands at the
  // first slot whose occupant does not outrank it; lower slots shift down.
  always_comb begin
    o_list = i_list;
    if (i_en) begin
      if (!w_ge[0]) begin
        o_list[0] = i_entry;
      end
      for (int i = 1; i < PEAKS; i++) begin
        if (!w_ge[i]) begin
          o_list[i] = w_ge[i-1] ? i_entry : i_list[i-1];
        end
      end
    end
  end
endmodule

// File: rtl/peak_select.sv
// Collects per-frame candidate bins and reports the PEAKS largest flagged peaks.
// Optional macro PEAK_THRESHOLD_EN adds a threshold input gating peak insertion.
module peak_select #(
  parameter int PEAKS            = 6,
  parameter int FREQS            = 256,
  parameter int INPUT_AMPL_WIDTH = 24,
  parameter int FINAL_AMPL_WIDTH = 16,
  parameter int FREQ_WIDTH       = 8
) (
  input  logic                                    CLOCK_50,
  input  logic                                    reset,
  input  logic                                    cand_valid,
  output logic                                    cand_ready,
  input  logic [INPUT_AMPL_WIDTH-1:0]             cand_ampl,
  input  logic                                    cand_is_peak,
  input  logic                                    cand_last,
`ifdef PEAK_THRESHOLD_EN
  input  logic [INPUT_AMPL_WIDTH-1:0]             threshold,
`endif
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0]  amplitude,
  output logic [PEAKS-1:0][FREQ_WIDTH-1:0]        freq,
  output logic [PEAKS-1:0]                        slot_valid,
  output logic                                    overrun,
  output logic                                    dbg_state
);
  import peaks_pkg::*;

  // Handshakes: a beat moves on a rising edge where valid && ready are both
  // high; valid/data hold until taken and ready never depends on valid.
  state_t                                r_state;
  logic                                  r_cand_ready;
  logic                                  r_out_valid;
  logic                                  r_overrun;
  logic [FREQ_WIDTH-1:0]                 r_bin;
  peak_entry_t [PEAKS-1:0]               r_list;
  logic [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] r_amp;
  logic [PEAKS-1:0][FREQ_WIDTH-1:0]      r_freq;
  logic [PEAKS-1:0]                      r_slot_valid;

  logic                    w_xfer;
  logic                    w_at_end;
  logic                    w_end;
  logic                    w_eligible;
  peak_entry_t             w_new;
  peak_entry_t [PEAKS-1:0] w_next;

  assign w_xfer   = cand_valid && r_cand_ready;
  assign w_at_end = (r_bin == FREQ_WIDTH'(FREQS - 1));
  assign w_end    = cand_last || w_at_end;

`ifdef PEAK_THRESHOLD_EN
  assign w_eligible = cand_is_peak && (cand_ampl >= threshold);
`else
  assign w_eligible = cand_is_peak;
`endif

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.ampl  = cand_ampl;
    w_new.freq  = r_bin;
  end

  peak_insert u_insert (
    .i_list  (r_list),
    .i_entry (w_new),
    .i_en    (w_xfer && w_eligible),
    .o_list  (w_next)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_COLLECT;
      r_cand_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_bin        <= '0;
      r_list       <= '0;
      r_amp        <= '0;
      r_freq       <= '0;
      r_slot_valid <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          r_cand_ready <= 1'b1;
          if (w_xfer) begin
            if (w_end) begin
              // Closing bin is included in the latched list; the working list
              // restarts empty so the next frame begins clean after the handshake.
              r_state      <= ST_HOLD;
              r_cand_ready <= 1'b0;
              r_out_valid  <= 1'b1;
              r_bin        <= '0;
              r_list       <= '0;
              for (int i = 0; i < PEAKS; i++) begin
                r_amp[i]        <= w_next[i].ampl[INPUT_AMPL_WIDTH-1 -: FINAL_AMPL_WIDTH];
                r_freq[i]       <= w_next[i].freq;
                r_slot_valid[i] <= w_next[i].valid;
              end
              if (w_at_end && !cand_last) begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_list <= w_next;
              r_bin  <= r_bin + FREQ_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state      <= ST_COLLECT;
            r_out_valid  <= 1'b0;
            r_cand_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign cand_ready = r_cand_ready;
  assign out_valid  = r_out_valid;
  assign overrun    = r_overrun;
  assign amplitude  = r_amp;
  assign freq       = r_freq;
  assign slot_valid = r_slot_valid;
  assign dbg_state  = r_state;
endmodule
